// File: rtl/avmm_ccip_cmd_bridge.sv
// Avalon-MM slave to CCI-P command-stream bridge: splits bursts into 64-byte line commands and returns read data in order.
// Optional simulation checks are enabled by defining AVMM_CCIP_CMD_BRIDGE_CHECK_EN.
module avmm_ccip_cmd_bridge #(
    parameter int AVMM_ADDR_WIDTH    = 48,
    parameter int AVMM_DATA_WIDTH    = 512,
    parameter int AVMM_BURST_WIDTH   = 4,
    parameter int MAX_OUTSTANDING_RD = 64
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [AVMM_ADDR_WIDTH-1:0]                 avs_address,
    input  logic                                       avs_read,
    input  logic                                       avs_write,
    input  logic [AVMM_DATA_WIDTH-1:0]                 avs_writedata,
    input  logic [AVMM_BURST_WIDTH-1:0]                avs_burstcount,
    output logic                                       avs_waitrequest,
    output logic [AVMM_DATA_WIDTH-1:0]                 avs_readdata,
    output logic                                       avs_readdatavalid,
    output logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH:0]   avst_avcmd_data,
    output logic                                       avst_avcmd_valid,
    input  logic                                       avst_avcmd_ready,
    input  logic [AVMM_DATA_WIDTH-1:0]                 avst_rd_rsp_data,
    input  logic                                       avst_rd_rsp_valid,
    output logic                                       avst_rd_rsp_ready
);

    localparam int CMD_W = AVMM_ADDR_WIDTH + AVMM_DATA_WIDTH + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING_RD + (1 << AVMM_BURST_WIDTH)) + 1;
    localparam logic [AVMM_ADDR_WIDTH-1:0] LINE_BYTES = AVMM_ADDR_WIDTH'(64);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;

    logic [1:0]                  state;
    logic [AVMM_BURST_WIDTH-1:0] remaining;
    logic [OUT_W-1:0]            outstanding;
    logic [AVMM_ADDR_WIDTH-1:0]  next_addr;
    logic                        cmd_valid;
    logic [CMD_W-1:0]            cmd_data;
    logic                        rsp_ready;
    logic                        rsp_vld_p1;
    logic [AVMM_DATA_WIDTH-1:0]  rsp_data_p1;

    logic                        slot_free;
    logic [AVMM_BURST_WIDTH-1:0] burst_len;
    logic                        credit_ok;
    logic [AVMM_ADDR_WIDTH-1:0]  base_addr;
    logic [AVMM_ADDR_WIDTH-1:0]  cmd_addr;
    logic                        rd_accept;
    logic                        wr_accept;
    logic                        rd_beat;
    logic                        load;
    logic                        rsp_beat;
    logic [CMD_W-1:0]            cmd_next;
    logic                        unused_low_addr;

    // Low address bits select a byte within the line and never reach the host.
    assign unused_low_addr = ^avs_address[5:0];

    assign slot_free = ~cmd_valid | avst_avcmd_ready;
    assign burst_len = (avs_burstcount == '0) ? AVMM_BURST_WIDTH'(1) : avs_burstcount;
    assign credit_ok = (outstanding + OUT_W'(burst_len)) <= OUT_W'(MAX_OUTSTANDING_RD);
    assign base_addr = {avs_address[AVMM_ADDR_WIDTH-1:6], 6'd0};
    assign cmd_addr  = (state == IDLE) ? base_addr : next_addr;

    assign rd_accept = ~reset & (state == IDLE) & avs_read & slot_free & credit_ok;
    assign wr_accept = ~reset & avs_write & slot_free &
                       (((state == IDLE) & ~avs_read) | (state == WR_BURST));
    assign rd_beat   = ~reset & (state == RD_BURST) & slot_free;
    assign load      = rd_accept | wr_accept | rd_beat;
    assign rsp_beat  = avst_rd_rsp_valid & rsp_ready;

    always_comb begin
        if (rd_accept || rd_beat) begin
            cmd_next = {cmd_addr, {AVMM_DATA_WIDTH{1'b0}}, 1'b1};
        end else begin
            cmd_next = {cmd_addr, avs_writedata, 1'b0};
        end
    end

    always_comb begin
        avs_waitrequest = 1'b1;
        if (!reset) begin
            case (state)
                IDLE:     avs_waitrequest = avs_read ? ~(slot_free & credit_ok) : ~slot_free;
                WR_BURST: avs_waitrequest = ~slot_free;
                default:  avs_waitrequest = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            outstanding <= '0;
            cmd_valid   <= 1'b0;
            rsp_ready   <= 1'b0;
            rsp_vld_p1  <= 1'b0;
        end else begin
            rsp_ready  <= 1'b1;
            rsp_vld_p1 <= rsp_beat;

            if (load) begin
                cmd_valid <= 1'b1;
            end else if (avst_avcmd_ready) begin
                cmd_valid <= 1'b0;
            end

            // Accept and response in the same cycle net out in one update.
            outstanding <= outstanding + (rd_accept ? OUT_W'(burst_len) : '0)
                                       - (rsp_beat ? OUT_W'(1) : '0);

            case (state)
                IDLE: begin
                    if (rd_accept || wr_accept) begin
                        remaining <= burst_len - AVMM_BURST_WIDTH'(1);
                        if (burst_len != AVMM_BURST_WIDTH'(1)) begin
                            state <= rd_accept ? RD_BURST : WR_BURST;
                        end
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (rd_beat || wr_accept) begin
                        remaining <= remaining - AVMM_BURST_WIDTH'(1);
                        if (remaining == AVMM_BURST_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path registers carry no reset; cmd_valid and rsp_vld_p1 qualify them.
    always_ff @(posedge clk) begin
        if (load) begin
            cmd_data  <= cmd_next;
            next_addr <= cmd_addr + LINE_BYTES;
        end
        rsp_data_p1 <= avst_rd_rsp_data;
    end

    assign avst_avcmd_valid  = cmd_valid;
    assign avst_avcmd_data   = cmd_data;
    assign avst_rd_rsp_ready = rsp_ready;
    assign avs_readdatavalid = rsp_vld_p1;
    assign avs_readdata      = rsp_data_p1;

`ifdef AVMM_CCIP_CMD_BRIDGE_CHECK_EN
    logic             chk_hold;
    logic [CMD_W-1:0] chk_data;

    always_ff @(posedge clk) begin
        chk_hold <= ~reset & cmd_valid & ~avst_avcmd_ready;
        chk_data <= cmd_data;
        if (!reset) begin
            if (avs_read && avs_write)
                $error("avmm_ccip_cmd_bridge: avs_read and avs_write asserted together");
            if (avst_rd_rsp_valid && outstanding == '0)
                $error("avmm_ccip_cmd_bridge: read response with no outstanding reads");
            if ((avs_read || avs_write) && avs_address[5:0] != 6'd0)
                $error("avmm_ccip_cmd_bridge: avs_address not line aligned");
            if (chk_hold && cmd_data != chk_data)
                $error("avmm_ccip_cmd_bridge: command data changed while stalled");
        end
    end
`else
    // Checks compiled out; functional behaviour is unchanged.
`endif

endmodule

// File: tb/tb_avmm_ccip_cmd_bridge.sv
// Randomized bench for avmm_ccip_cmd_bridge: a queue-based model predicts the line command stream and read data order.
module tb_avmm_ccip_cmd_bridge;

    localparam int A  = 48;
    localparam int D  = 512;
    localparam int B  = 4;
    localparam int CW = A + D + 1;
    localparam int MAXRD = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [A-1:0]  avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [D-1:0]  avs_writedata = '0;
    logic [B-1:0]  avs_burstcount = '0;
    logic          avs_waitrequest;
    logic [D-1:0]  avs_readdata;
    logic          avs_readdatavalid;
    logic [CW-1:0] avst_avcmd_data;
    logic          avst_avcmd_valid;
    logic          avst_avcmd_ready = 1'b1;
    logic [D-1:0]  avst_rd_rsp_data = '0;
    logic          avst_rd_rsp_valid = 1'b0;
    logic          avst_rd_rsp_ready;

    int total = 0;
    int bad = 0;
    int rdy_mode = 0;
    int pend = 0;
    bit acc_flag = 0;
    logic [CW-1:0] exp_q[$];
    logic [D-1:0]  rsp_q[$];

    avmm_ccip_cmd_bridge #(
        .AVMM_ADDR_WIDTH(A), .AVMM_DATA_WIDTH(D),
        .AVMM_BURST_WIDTH(B), .MAX_OUTSTANDING_RD(MAXRD)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_burstcount(avs_burstcount),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avst_avcmd_data(avst_avcmd_data), .avst_avcmd_valid(avst_avcmd_valid),
        .avst_avcmd_ready(avst_avcmd_ready),
        .avst_rd_rsp_data(avst_rd_rsp_data), .avst_rd_rsp_valid(avst_rd_rsp_valid),
        .avst_rd_rsp_ready(avst_rd_rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [D-1:0] rnd512();
        logic [D-1:0] r;
        for (int i = 0; i < D / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [A-1:0] line_addr(logic [A-1:0] a, int beat);
        logic [A-1:0] base;
        base = a & ~A'(63);
        return base + A'(64 * beat);
    endfunction

    // Host-side ready pattern: 0 always ready, 1 toggling, 2 random
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       avst_avcmd_ready = ~avst_avcmd_ready;
                2:       avst_avcmd_ready = 1'($urandom_range(0, 1));
                default: avst_avcmd_ready = 1'b1;
            endcase
        end
    end

    // Command stream and read-data monitor
    bit            hold_prev = 0;
    logic [CW-1:0] hold_data;
    always @(negedge clk) begin
        if (hold_prev) begin
            total++;
            if (avst_avcmd_valid !== 1'b1 || avst_avcmd_data !== hold_data) begin
                bad++;
                $display("FAIL hold_stable: got valid=%b addr=%h want valid=1 addr=%h",
                         avst_avcmd_valid, avst_avcmd_data[CW-1 -: A], hold_data[CW-1 -: A]);
            end
        end
        if (avst_avcmd_valid && avst_avcmd_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cmd_unexpected: got addr=%h ctrl=%b want none",
                         avst_avcmd_data[CW-1 -: A], avst_avcmd_data[0]);
            end else begin
                logic [CW-1:0] e;
                e = exp_q.pop_front();
                if (avst_avcmd_data !== e) begin
                    bad++;
                    $display("FAIL cmd: got addr=%h ctrl=%b data=%h want addr=%h ctrl=%b data=%h",
                             avst_avcmd_data[CW-1 -: A], avst_avcmd_data[0], avst_avcmd_data[D:1],
                             e[CW-1 -: A], e[0], e[D:1]);
                end
            end
        end
        hold_prev = !reset && avst_avcmd_valid && !avst_avcmd_ready;
        hold_data = avst_avcmd_data;
        if (avs_readdatavalid) begin
            total++;
            if (rsp_q.size() == 0) begin
                bad++;
                $display("FAIL rdata_unexpected: got %h want none", avs_readdata[63:0]);
            end else begin
                logic [D-1:0] r;
                r = rsp_q.pop_front();
                if (avs_readdata !== r) begin
                    bad++;
                    $display("FAIL rdata: got %h want %h", avs_readdata, r);
                end
            end
        end
    end

    task automatic wait_accept(input string name, output int waits);
        waits = 0;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            waits++;
            if (waits > 300) begin
                total++; bad++;
                $display("FAIL %s_timeout: got waitrequest=1 after %0d cycles want 0", name, waits);
                break;
            end
        end
    endtask

    task automatic do_read(input logic [A-1:0] a, input logic [B-1:0] bc, output int waits);
        int n;
        n = (bc == 0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) exp_q.push_back({line_addr(a, i), {D{1'b0}}, 1'b1});
        @(posedge clk); #1;
        avs_read = 1'b1; avs_address = a; avs_burstcount = bc;
        wait_accept("read", waits);
        @(posedge clk); #1;
        avs_read = 1'b0;
        pend += n;
        acc_flag = 1'b1;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [B-1:0] bc);
        int n;
        int w;
        logic [D-1:0] d;
        n = (bc == 0) ? 1 : int'(bc);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            d = rnd512();
            exp_q.push_back({line_addr(a, i), d, 1'b0});
            avs_write = 1'b1; avs_writedata = d;
            if (i == 0) begin
                avs_address = a; avs_burstcount = bc;
            end else begin
                avs_address = {$urandom, $urandom}; avs_burstcount = B'($urandom);
            end
            wait_accept("write", w);
            @(posedge clk); #1;
        end
        avs_write = 1'b0;
    endtask

    task automatic send_rsp(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            avst_rd_rsp_valid = 1'b1;
            avst_rd_rsp_data = rnd512();
            rsp_q.push_back(avst_rd_rsp_data);
            pend--;
        end
        @(posedge clk); #1;
        avst_rd_rsp_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 500 && (exp_q.size() != 0 || rsp_q.size() != 0); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0 || rsp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got cmds_left=%0d rsp_left=%0d want 0 0", name, exp_q.size(), rsp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({avs_waitrequest, avst_avcmd_valid, avs_readdatavalid, avst_rd_rsp_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_state: got wr/vld/rdv/rdy=%b want 1000",
                     {avs_waitrequest, avst_avcmd_valid, avs_readdatavalid, avst_rd_rsp_ready});
        end
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if (avst_rd_rsp_ready !== 1'b1 || avs_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%b wr=%b want 1 0", avst_rd_rsp_ready, avs_waitrequest);
        end
    endtask

    task automatic test_single_read();
        int w;
        logic [D-1:0] d;
        rdy_mode = 0;
        do_read(48'h1000, 4'd1, w);
        total++;
        if (w != 0) begin bad++; $display("FAIL single_read_wait: got %0d want 0", w); end
        d = rnd512();
        @(posedge clk); #1;
        avst_rd_rsp_valid = 1'b1; avst_rd_rsp_data = d; rsp_q.push_back(d); pend--;
        @(negedge clk);
        total++;
        if (avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL rsp_latency_early: got 1 want 0"); end
        @(posedge clk); #1;
        avst_rd_rsp_valid = 1'b0;
        @(negedge clk);
        total++;
        if (avs_readdatavalid !== 1'b1 || avs_readdata !== d) begin
            bad++;
            $display("FAIL rsp_latency: got vld=%b data=%h want 1 %h", avs_readdatavalid, avs_readdata[63:0], d[63:0]);
        end
        drain("single_read");
    endtask

    task automatic test_read_burst();
        int w;
        int cnt;
        rdy_mode = 0;
        do_read(48'h2000, 4'd4, w);
        exp_q.push_back({48'h3000, {D{1'b0}}, 1'b1});
        avs_read = 1'b1; avs_address = 48'h3000; avs_burstcount = 4'd1;
        wait_accept("burst_hold", cnt);
        @(posedge clk); #1;
        avs_read = 1'b0; pend += 1;
        total++;
        if (cnt != 3) begin bad++; $display("FAIL burst_waitrequest: got %0d wait cycles want 3", cnt); end
        send_rsp(pend);
        drain("read_burst");
    endtask

    task automatic test_write_wrap();
        rdy_mode = 1;
        do_write(48'hFFFF_FFFF_FFC0, 4'd3);
        drain("write_wrap");
        rdy_mode = 2;
        do_write(48'h0000_1234_5678, 4'd0);
        do_write(48'h0000_0000_4000, 4'd8);
        drain("write_misc");
    endtask

    task automatic test_rw_collision();
        int w;
        logic [D-1:0] d;
        rdy_mode = 0;
        d = rnd512();
        exp_q.push_back({48'hC000, {D{1'b0}}, 1'b1});
        exp_q.push_back({48'hC000, d, 1'b0});
        @(posedge clk); #1;
        avs_read = 1'b1; avs_write = 1'b1; avs_address = 48'hC015;
        avs_burstcount = 4'd1; avs_writedata = d;
        wait_accept("collide_rd", w);
        @(posedge clk); #1;
        avs_read = 1'b0; pend += 1;
        wait_accept("collide_wr", w);
        @(posedge clk); #1;
        avs_write = 1'b0;
        send_rsp(pend);
        drain("rw_collision");
    endtask

    task automatic test_credit();
        int w;
        int w2;
        rdy_mode = 0;
        do_read(48'h8000, 4'd8, w);
        acc_flag = 1'b0;
        fork
            do_read(48'h9000, 4'd8, w2);
        join_none
        repeat (20) @(posedge clk);
        total++;
        if (acc_flag !== 1'b0) begin bad++; $display("FAIL credit_stall: got accepted want stalled"); end
        send_rsp(1);
        repeat (10) @(posedge clk);
        total++;
        if (acc_flag !== 1'b0) begin bad++; $display("FAIL credit_stall_one: got accepted want stalled"); end
        send_rsp(7);
        for (int i = 0; i < 20 && !acc_flag; i++) @(posedge clk);
        total++;
        if (acc_flag !== 1'b1) begin bad++; $display("FAIL credit_release: got stalled want accepted"); end
        wait fork;
        send_rsp(pend);
        drain("credit");
    endtask

    task automatic test_concurrent();
        int w;
        int w2;
        rdy_mode = 0;
        do_read(48'h5000, 4'd8, w);
        fork
            do_read(48'h6000, 4'd1, w2);
            send_rsp(8);
        join
        acc_flag = 1'b0;
        fork
            do_read(48'h7000, 4'd8, w);
        join_none
        repeat (6) @(posedge clk);
        total++;
        if (acc_flag !== 1'b0) begin bad++; $display("FAIL net_credit_stall: got accepted want stalled"); end
        send_rsp(1);
        for (int i = 0; i < 20 && !acc_flag; i++) @(posedge clk);
        total++;
        if (acc_flag !== 1'b1) begin bad++; $display("FAIL net_credit_release: got stalled want accepted"); end
        wait fork;
        send_rsp(pend);
        drain("concurrent");
    endtask

    task automatic test_reset_mid_burst();
        int w;
        rdy_mode = 0;
        do_read(48'hA000, 4'd8, w);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        pend = 0;
        total++;
        if (avst_avcmd_valid !== 1'b0 || avs_waitrequest !== 1'b1 || avst_rd_rsp_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got vld=%b wr=%b rdy=%b want 0 1 0",
                     avst_avcmd_valid, avs_waitrequest, avst_rd_rsp_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (avst_avcmd_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_residual: got valid=1 addr=%h want valid=0", avst_avcmd_data[CW-1 -: A]);
            end
        end
        do_read(48'hB000, 4'd8, w);
        total++;
        if (w != 0) begin bad++; $display("FAIL reset_credit: got %0d wait cycles want 0", w); end
        send_rsp(pend);
        drain("reset_mid");
    endtask

    task automatic test_random();
        int w;
        int n;
        logic [A-1:0] a;
        logic [B-1:0] bc;
        rdy_mode = 2;
        for (int t = 0; t < 16; t++) begin
            a = {$urandom, $urandom};
            bc = B'($urandom_range(0, 8));
            n = (bc == 0) ? 1 : int'(bc);
            if ($urandom_range(0, 1) == 1) begin
                if (pend + n > MAXRD) send_rsp(pend);
                do_read(a, bc, w);
            end else begin
                do_write(a, bc);
            end
        end
        send_rsp(pend);
        drain("random");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_read_burst();
        test_write_wrap();
        test_rw_collision();
        test_credit();
        test_concurrent();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
